spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Round-robin SPI master that shares one SPI bus between four requesters, each owning one slave. Drives the 5-bit active-low chip-select code consumed by the downstream MISO decoder, and generates SCLK/MOSI in SPI mode 0. Takes the decoder's selected MISO back and returns received words. Sits between the modem's control agents and the board SPI pins.

## Interface
- `DATA_W`, default 16: bits per transfer; legal range 8–32.
- `CLK_DIV`, default 4: system clocks per SCLK half-period; minimum 2.
- `CS_SETUP`, default 2: clocks from CS low to the first SCLK activity; minimum 1.
- `CS_HOLD`, default 2: clocks from the last SCLK fall to CS high; minimum 1.
- `clk` input, 1 bit: system clock. This block has one clock domain.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, 4 bits: level request per requester; hold until that requester's `done`.
- `tx_data` input, 4*DATA_W bits: requester i's word in slice [i*DATA_W +: DATA_W]; sampled at grant.
- `grant` output, 4 bits: one-hot; identifies the requester owning the bus for the whole transaction.
- `done` output, 4 bits: one-cycle pulse on the served requester's bit.
- `rx_data` output, DATA_W bits: last received word; valid from `done` until the next `done`.
- `busy` output, 1 bit: high in every state except IDLE.
- `cs_code` output, 5 bits: chip-select code, active low. Bit i is low for slave i. Bit 4 is always 1.
- `sclk` output, 1 bit: SPI clock with CPOL=0.
- `mosi` output, 1 bit: serial data out.
- `miso` input, 1 bit: serial data in, taken from the MISO decoder output.

## Operation
- FSM states: IDLE → SETUP → SHIFT → HOLD → RELEASE → IDLE.
- **IDLE**
  - Any `req` bit high at a clock edge: round-robin pick, searching from (last_served+1) mod 4 upward.
  - At that same edge: register the winner's `grant` bit, clear its `cs_code` bit, load the shift register from the winner's `tx_data`, drive `mosi` with the first bit.
  - Move to SETUP.
- **SETUP**: hold for CS_SETUP clocks with `sclk`=0.
- **SHIFT**
  - A divider counts 0..CLK_DIV-1; `sclk` toggles on each wrap.
  - At the edge that drives `sclk` 0→1, sample `miso` into the receive shift register.
  - At the edge that drives `sclk` 1→0, shift out the next `mosi` bit. There is no shift after the final fall; `mosi` holds.
  - Leave SHIFT after DATA_W rising and DATA_W falling edges, with `sclk` low.
- **HOLD**: CS_HOLD clocks with `cs_code` still asserted.
- **RELEASE** (1 clock)
  - `cs_code`=5'b11111 and `grant`=0.
  - `done[winner]`=1 and `rx_data` updated.
  - `last_served` ← winner.
- Bit order is MSB first by default.
- A requester that drops `req` mid-transaction does not abort the transfer. New requests are examined only in IDLE.
- `cs_code` only ever takes the values 11110, 11101, 11011, 10111 or 11111.
- Reset values: state=IDLE, `cs_code`=5'b11111, `sclk`=0, `mosi`=0, `grant`=0, `done`=0, `busy`=0, `rx_data`=0, last_served=3 so that requester 0 wins first.
- Reset asserted mid-transaction forces all outputs to their reset values immediately, with no `done` pulse.

## Timing
- The grant edge and the CS-low edge are the same edge. All outputs are registered.
- Clocks from grant to the `done` pulse, inclusive of SETUP through HOLD: CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD. With defaults this is 132.
- CS stays high for at least 2 clocks (RELEASE + IDLE) between transactions.
- Back-to-back grants to different slaves therefore occur every 134 clocks with defaults.
- The first `sclk` rise occurs CS_SETUP + CLK_DIV clocks after the grant edge.

## Configuration
- `SPI_ARB_LSB_FIRST_EN` defined: transmit and receive LSB first, for both `mosi` and `rx_data` assembly.
- Undefined: MSB first.
- All timing is identical in both cases.

## Structure
- Shared package `spi_arb_pkg` holds:
  - the FSM state enum;
  - `CS_IDLE`=5'b11111;
  - the function mapping a requester index to its `cs_code`.
- Sub-module `spi_rr_picker`: combinational round-robin over 4 requests plus last_served, producing a one-hot winner. Everything else stays in the top module.

## Test plan
- req=0010 with tx_data slice 1=0xA5C3 and `miso` looped from `mosi` → `cs_code`=11101 throughout, 16 `sclk` rises, rx_data=0xA5C3, `done`=0010 for 1 clock exactly 132 clocks after grant.
- req=1111 held continuously from reset → grant order 0001, 0010, 0100, 1000, 0001. Each `done` clears its `req`.
- req[1] held; req[3] raised mid-transfer of 1 → next grant goes to 3, then to 1.
- `miso` tied 1 → rx_data=0xFFFF. `miso` tied 0 → 0x0000. `cs_code` is never outside the five legal values.
- `rst_n` pulsed low during SHIFT (bit 7) → `cs_code`=11111, `sclk`=0 and `grant`=0 within the same clock, no `done`. After release, a fresh req=0001 completes normally.
- With `SPI_ARB_LSB_FIRST_EN`, tx=0x0001 looped back → the first `mosi` bit is 1 and rx_data=0x0001.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: types and helpers shared by the SPI bus arbiter files.
//   arb_state_t : transaction FSM states
//   CS_IDLE     : chip-select code with no slave selected
//   cs_of()     : requester index -> active-low chip-select code
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_RELEASE
    } arb_state_t;

    localparam logic [4:0] CS_IDLE = 5'b11111;

    // Bit 4 has no slave behind it, so it is never cleared.
    function automatic logic [4:0] cs_of(input logic [1:0] idx);
        cs_of = CS_IDLE & ~(5'b00001 << idx);
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin choice among four requests.
//   i_req  [3:0] : request levels
//   i_last [1:0] : index of the requester served last
//   o_win  [3:0] : one-hot winner, zero when nothing is requested
// The search starts at (i_last + 1) mod 4 and moves upward, wrapping.
module spi_rr_picker (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [3:0] o_win
);

    logic [1:0] w_start;
    logic [1:0] w_off;
    logic [3:0] w_rot;
    logic       w_found;

    always_comb begin
        w_start = i_last + 2'd1;
        // Rotate so that the first candidate sits at bit 0; a shift by 4
        // yields zero, which makes the w_start == 0 case a plain copy.
        w_rot   = (i_req >> w_start) | (i_req << (3'd4 - {1'b0, w_start}));
        w_off   = 2'd0;
        w_found = 1'b0;
        // Walk downward so the lowest set bit is the one that sticks.
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = 2'(k);
                w_found = 1'b1;
            end
        end
        o_win = w_found ? (4'b0001 << (w_start + w_off)) : 4'b0000;
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI bus (mode 0) between four requesters,
// each owning one slave selected through an active-low chip-select code.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   req     [3:0]    : level requests, held until the matching done
//   tx_data [4*W-1:0]: requester i word in [i*W +: W], sampled at grant
//   grant   [3:0]    : one-hot bus owner for the whole transaction
//   done    [3:0]    : one-cycle completion pulse for the served requester
//   rx_data [W-1:0]  : last received word
//   busy             : high whenever the FSM is not idle
//   cs_code [4:0]    : active-low chip select, bit 4 always high
//   sclk, mosi, miso : SPI pins (CPOL=0, CPHA=0)
// Build option: define SPI_ARB_LSB_FIRST_EN to shift LSB first on both
// mosi and rx_data; otherwise MSB first. Timing is the same either way.
//
// state      | meaning
// IDLE       | bus free, round-robin pick on any request
// SETUP      | CS low, sclk low, CS_SETUP clocks
// SHIFT      | DATA_W sclk periods, sample on rise, shift on fall
// HOLD       | CS still low for CS_HOLD clocks after the last fall
// RELEASE    | CS high, grant dropped, done pulse, rx_data updated
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   tx_data,
    output logic [3:0]            grant,
    output logic [3:0]            done,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  busy,
    output logic [4:0]            cs_code,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t          r_state;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bits;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_last;
    logic [1:0]          r_idx;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;

    logic [3:0]          w_win;
    logic [1:0]          w_win_idx;
    logic [DATA_W-1:0]   w_tx_sel;
    logic [DATA_W-1:0]   w_tx_shifted;
    logic [DATA_W-1:0]   w_rx_shifted;

    spi_rr_picker u_picker (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_win)
    );

    always_comb begin
        w_win_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_win[k]) begin
                w_win_idx = 2'(k);
            end
        end
        w_tx_sel = tx_data[w_win_idx*DATA_W +: DATA_W];
    end

    // mosi is taken straight from the end of the transmit register, so it
    // is a flop output and simply holds once shifting stops.
`ifdef SPI_ARB_LSB_FIRST_EN
    assign mosi         = r_tx[0];
    assign w_tx_shifted = r_tx >> 1;
    assign w_rx_shifted = {miso, r_rx[DATA_W-1:1]};
`else
    assign mosi         = r_tx[DATA_W-1];
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = {r_rx[DATA_W-2:0], miso};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bits  <= '0;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_idx   <= 2'd0;
            r_tx    <= '0;
            r_rx    <= '0;
            grant   <= 4'b0000;
            done    <= 4'b0000;
            rx_data <= '0;
            busy    <= 1'b0;
            cs_code <= CS_IDLE;
            sclk    <= 1'b0;
        end else begin
            done <= 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        grant   <= w_win;
                        cs_code <= cs_of(w_win_idx);
                        r_idx   <= w_win_idx;
                        r_tx    <= w_tx_sel;
                        r_cnt   <= CNT_W'(CS_SETUP - 1);
                        busy    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_div   <= '0;
                        r_bits  <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_div == DIV_W'(CLK_DIV - 1)) begin
                        r_div <= '0;
                        sclk  <= ~sclk;
                        if (!sclk) begin
                            r_rx <= w_rx_shifted;
                        end else if (r_bits == BIT_W'(DATA_W - 1)) begin
                            // Final fall: no further shift, mosi holds.
                            r_cnt   <= CNT_W'(CS_HOLD - 1);
                            r_state <= ST_HOLD;
                        end else begin
                            r_bits <= r_bits + 1'b1;
                            r_tx   <= w_tx_shifted;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        cs_code <= CS_IDLE;
                        grant   <= 4'b0000;
                        done    <= grant;
                        rx_data <= r_rx;
                        r_last  <= r_idx;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter with default parameters.
// A transaction-timeline model predicts every output from the offset since
// the grant edge; directed tests add hand-computed literal expectations.
module tb_spi_bus_arbiter;

    localparam int DW  = 16;
    localparam int CD  = 4;
    localparam int CSU = 2;
    localparam int CH  = 2;
    localparam int TXN = CSU + 2*DW*CD + CH;   // grant edge to done edge
`ifdef SPI_ARB_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [4*DW-1:0] tx_data = '0;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic [DW-1:0]   rx_data;
    logic            busy;
    logic [4:0]      cs_code;
    logic            sclk;
    logic            mosi;
    logic            miso;
    int              miso_mode = 0;    // 0: tied 0, 1: tied 1, 2: loopback

    assign miso = (miso_mode == 2) ? mosi : (miso_mode == 1);

    always #5 clk = ~clk;

    spi_bus_arbiter #(.DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(CSU), .CS_HOLD(CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .tx_data (tx_data),
        .grant   (grant),
        .done    (done),
        .rx_data (rx_data),
        .busy    (busy),
        .cs_code (cs_code),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    bit            m_act = 1'b0;
    int            m_n = 0;
    int            m_last = 3;
    int            m_win = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_rx = '0;
    logic [DW-1:0] m_rx_next = '0;
    logic          m_mosi_idle = 1'b0;
    int            cyc = 0;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic exp_mosi(input logic [DW-1:0] w, input int n);
        int idx;
        idx = (n < CSU) ? 0 : (n - CSU) / (2*CD);
        if (idx > DW-1) idx = DW-1;
        return LSB ? w[idx] : w[DW-1-idx];
    endfunction

    function automatic logic exp_sclk(input int n);
        if (n < CSU || n >= CSU + 2*DW*CD) return 1'b0;
        return (((n - CSU) / CD) % 2) == 1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 1'b0; m_n = 0; m_last = 3; m_win = 0;
            m_rx = '0; m_mosi_idle = 1'b0;
        end else begin
            cyc++;
            if (m_act) begin
                m_n++;
                if (m_n == TXN) begin
                    m_last = m_win;
                    m_rx = m_rx_next;
                    m_mosi_idle = exp_mosi(m_word, TXN);
                end
                if (m_n == TXN + 1) m_act = 1'b0;
            end else if (req != 4'b0000) begin
                m_win  = rr_pick(req, m_last);
                m_word = tx_data[m_win*DW +: DW];
                m_rx_next = (miso_mode == 2) ? m_word : ((miso_mode == 1) ? '1 : '0);
                m_n = 0;
                m_act = 1'b1;
            end
        end
    end

    // ---------------- compare + event log ----------------
    logic [3:0] g_val[$];
    int         g_cyc[$];
    logic [3:0] d_val[$];
    int         d_cyc[$];
    int         rises = 0;
    int         first_rise_cyc = 0;
    logic [3:0] prev_grant = 4'b0000;
    logic       prev_sclk = 1'b0;

    initial forever begin
        logic [3:0] eg, ed;
        logic [4:0] ecs;
        logic       eb, es, em;
        @(negedge clk);
        if (!rst_n) begin
            prev_grant = 4'b0000;
            prev_sclk = 1'b0;
        end else begin
            if (m_act) begin
                eg  = (m_n < TXN) ? (4'b0001 << m_win) : 4'b0000;
                ecs = (m_n < TXN) ? (5'b11111 & ~(5'b00001 << m_win)) : 5'b11111;
                eb  = 1'b1;
                ed  = (m_n == TXN) ? (4'b0001 << m_win) : 4'b0000;
                es  = exp_sclk(m_n);
                em  = exp_mosi(m_word, m_n);
            end else begin
                eg = 4'b0000; ecs = 5'b11111; eb = 1'b0; ed = 4'b0000;
                es = 1'b0; em = m_mosi_idle;
            end
            chk("cycle", {grant, cs_code, busy, done, sclk, mosi, rx_data},
                         {eg, ecs, eb, ed, es, em, m_rx});
            chk("cs_legal", (cs_code == 5'b11110 || cs_code == 5'b11101 || cs_code == 5'b11011 ||
                             cs_code == 5'b10111 || cs_code == 5'b11111), 1);
            if (grant != 4'b0000 && prev_grant == 4'b0000) begin
                g_val.push_back(grant);
                g_cyc.push_back(cyc);
                rises = 0;
            end
            if (sclk && !prev_sclk) begin
                rises++;
                if (rises == 1) first_rise_cyc = cyc;
            end
            if (done != 4'b0000) begin
                d_val.push_back(done);
                d_cyc.push_back(cyc);
            end
            prev_grant = grant;
            prev_sclk = sclk;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input int budget, output logic [3:0] d);
        d = 4'b0000;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != 4'b0000) begin
                d = done;
                return;
            end
        end
        chk("wait_done_timeout", 1, 0);
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) return;
        end
        chk("wait_grant_timeout", 1, 0);
    endtask

    task automatic wait_rises(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rises >= n) return;
        end
        chk("wait_rises_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    logic [3:0] d;
    int         base;
    int         nd;
    logic [3:0] exp_order2[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_order3[3] = '{4'b0010, 4'b1000, 4'b0010};

    initial begin
        // reset state
        #12;
        chk("reset_state", {grant, cs_code, busy, done, sclk, mosi, rx_data},
                           {4'b0000, 5'b11111, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000});
        @(negedge clk); #2 rst_n = 1'b1;

        // T1: single loopback transfer on requester 1
        tx_data[1*DW +: DW] = 16'hA5C3;
        miso_mode = 2;
        @(negedge clk);
        req = 4'b0010;
        base = g_val.size();
        wait_done(400, d);
        chk("t1_done", d, 4'b0010);
        chk("t1_rx", rx_data, 16'hA5C3);
        chk("t1_latency", d_cyc[d_cyc.size()-1] - g_cyc[base], 132);
        chk("t1_rises", rises, 16);
        chk("t1_first_rise", first_rise_cyc - g_cyc[base], 6);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_done_width", done, 4'b0000);

        // T2: all four requesting from reset, requester 0 kept asserted
        rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        tx_data = {16'h1111, 16'h2222, 16'h4444, 16'h8888};
        @(negedge clk);
        req = 4'b1111;
        base = g_val.size();
        for (int k = 0; k < 5; k++) begin
            wait_done(400, d);
            req = req & ~d;
            if (k == 0) req[0] = 1'b1;
        end
        for (int k = 0; k < 5; k++) chk("t2_order", g_val[base+k], exp_order2[k]);
        for (int k = 0; k < 3; k++) chk("t2_spacing", g_cyc[base+k+1] - g_cyc[base+k], 134);

        // T3: req[3] raised while requester 1 is mid-transfer, miso tied 1
        miso_mode = 1;
        @(negedge clk);
        req = 4'b0010;
        base = g_val.size();
        wait_grant(20);
        repeat (40) @(negedge clk);
        req[3] = 1'b1;
        wait_done(400, d);
        chk("t3_done_a", d, 4'b0010);
        chk("t3_rx_ones", rx_data, 16'hFFFF);
        wait_done(400, d);
        chk("t3_done_b", d, 4'b1000);
        req[3] = 1'b0;
        wait_done(400, d);
        chk("t3_done_c", d, 4'b0010);
        req = 4'b0000;
        for (int k = 0; k < 3; k++) chk("t3_order", g_val[base+k], exp_order3[k]);

        // T4: miso tied 0
        miso_mode = 0;
        @(negedge clk);
        req = 4'b0100;
        wait_done(400, d);
        chk("t4_done", d, 4'b0100);
        chk("t4_rx_zeros", rx_data, 16'h0000);
        req = 4'b0000;

        // T5: reset during SHIFT, then a clean transfer
        tx_data[0 +: DW] = 16'h3C5A;
        miso_mode = 2;
        repeat (3) @(negedge clk);
        req = 4'b0001;
        wait_grant(20);
        wait_rises(7, 300);
        nd = d_val.size();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_reset_now", {grant, cs_code, busy, done, sclk, mosi, rx_data},
                            {4'b0000, 5'b11111, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000});
        req = 4'b0000;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_done", d_val.size(), nd);
        req = 4'b0001;
        wait_done(400, d);
        chk("t5_done", d, 4'b0001);
        chk("t5_rx", rx_data, 16'h3C5A);
        req = 4'b0000;

        // T6: bit order with tx=0x0001 looped back
        tx_data[0 +: DW] = 16'h0001;
        repeat (3) @(negedge clk);
        req = 4'b0001;
        wait_grant(20);
        chk("t6_first_mosi", mosi, LSB ? 1 : 0);
        wait_done(400, d);
        chk("t6_rx", rx_data, 16'h0001);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
